// File: rtl/pulse_burst_counter_if.sv
// -----------------------------------------------------------------------------
// pulse_burst_counter_if
//   Bus between a pulse-burst measurement client and pulse_burst_counter.
//
//   Parameters
//     CW        width of the edge count
//
//   Signals
//     signal_in  pulse stream under measurement      (client -> counter)
//     start      measurement request                 (client -> counter)
//     busy       counting window open                (counter -> client)
//     done       one-cycle completion strobe         (counter -> client)
//     count      rising edges seen in the last window (counter -> client)
//     overflow   count saturated in the last window  (counter -> client)
//
//   Modports: master = client side, slave = counter side.
// -----------------------------------------------------------------------------
interface pulse_burst_counter_if #(
    parameter int CW = 8
);
    logic          signal_in;
    logic          start;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          overflow;

    modport master (
        output signal_in, start,
        input  busy, done, count, overflow
    );

    modport slave (
        input  signal_in, start,
        output busy, done, count, overflow
    );
endinterface

// File: rtl/pulse_burst_counter.sv
// -----------------------------------------------------------------------------
// pulse_burst_counter
//   Samples a pulse stream, detects rising edges and, on request, counts them
//   over a fixed window of WINDOW clock cycles. The result is reported with a
//   one-cycle done strobe; the count saturates at 2^CW-1 and flags overflow.
//
//   Parameters
//     WINDOW   counting window length in clock cycles (>= 1)
//     CW       edge count width
//
//   Ports
//     clock    clock, all state updates on the rising edge
//     reset_n  synchronous active-low reset
//     bus      pulse_burst_counter_if.slave (signal_in, start, busy, done,
//              count, overflow)
//
//   Build option
//     PULSE_SYNC_EN  when defined, signal_in passes through a two-flop
//                    synchronizer (edge-to-count latency 2 cycles); otherwise
//                    a single register for same-edge synchronous sources
//                    (latency 1 cycle).
// -----------------------------------------------------------------------------
module pulse_burst_counter #(
    parameter int WINDOW = 16,
    parameter int CW     = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    pulse_burst_counter_if.slave  bus
);

    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [WW-1:0] win_q,   win_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q,   ovf_d;
    logic          s1_q;
    logic          prev_q;
    logic          edge_w;

    // ---------------------------------------------------------------------
    // Input sampling
    // ---------------------------------------------------------------------
`ifdef PULSE_SYNC_EN
    logic s0_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s0_q <= 1'b0;
            s1_q <= 1'b0;
        end else begin
            s0_q <= bus.signal_in;
            s1_q <= s0_q;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
        end else begin
            s1_q <= bus.signal_in;
        end
    end
`endif

    // prev tracks s1 in every state, so a level that is already high when
    // the window opens never looks like an edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= s1_q;
        end
    end

    assign edge_w = s1_q & ~prev_q;

    // ---------------------------------------------------------------------
    // Measurement FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_COUNT;
                    win_d   = WW'(WINDOW - 1);
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_COUNT: begin
                if (edge_w) begin
                    if (&count_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                // An edge in the final cycle (win_q == 0) is still counted above.
                if (win_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    win_d = win_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == S_COUNT);
    assign bus.done     = (state_q == S_DONE);
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_pulse_burst_counter.sv
// -----------------------------------------------------------------------------
// tb_pulse_burst_counter
//   Two instances: A (WINDOW=16, CW=8) and B (WINDOW=32, CW=3, saturation).
//   A table of measurement vectors plus hand-written multi-cycle sequences.
//   Inputs change 1 time unit after the rising edge; outputs are sampled at
//   the same point, i.e. they reflect the state after that edge.
// -----------------------------------------------------------------------------
module tb_pulse_burst_counter;

`ifdef PULSE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clock;
    logic reset_n;

    pulse_burst_counter_if #(.CW(8)) ifa ();
    pulse_burst_counter_if #(.CW(3)) ifb ();

    pulse_burst_counter #(.WINDOW(16), .CW(8)) u_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifa.slave)
    );

    pulse_burst_counter #(.WINDOW(32), .CW(3)) u_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifb.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit b, input logic st, input logic sig);
        if (b) begin
            ifb.start = st; ifb.signal_in = sig;
        end else begin
            ifa.start = st; ifa.signal_in = sig;
        end
    endtask

    function automatic int cur_busy(input bit b);
        return b ? int'(ifb.busy) : int'(ifa.busy);
    endfunction

    function automatic int cur_done(input bit b);
        return b ? int'(ifb.done) : int'(ifa.done);
    endfunction

    function automatic int cur_count(input bit b);
        return b ? int'(ifb.count) : int'(ifa.count);
    endfunction

    function automatic int cur_ovf(input bit b);
        return b ? int'(ifb.overflow) : int'(ifa.overflow);
    endfunction

    // pat[j] is the signal level driven in window cycle j (j=0 alongside start).
    typedef struct {
        string       name;
        bit          dut_b;
        logic        pre;
        logic [31:0] pat;
        int          exp_cnt;
        int          exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        int nwin, nbusy, ndone, done_at;
        nwin = v.dut_b ? 32 : 16;
        drive(v.dut_b, 1'b0, v.pre);
        repeat (3) tick();
        nbusy = 0; ndone = 0; done_at = -1;
        for (int j = 0; j < nwin + 4; j++) begin
            drive(v.dut_b, j == 0, (j < nwin) ? v.pat[j] : 1'b0);
            tick();
            if (cur_busy(v.dut_b) != 0) nbusy++;
            if (cur_done(v.dut_b) != 0) begin
                ndone++;
                done_at = j;
            end
        end
        chk({v.name, ".busy_cycles"}, nbusy, nwin);
        chk({v.name, ".done_strobes"}, ndone, 1);
        chk({v.name, ".done_at"}, done_at, nwin);
        chk({v.name, ".count"}, cur_count(v.dut_b), v.exp_cnt);
        chk({v.name, ".overflow"}, cur_ovf(v.dut_b), v.exp_ovf);
    endtask

    initial begin
        int nbusy, ndone, done_at, bad;

        vecs[0] = '{"square2x2",   1'b0, 1'b0, 32'h0000_CCCC, 4, 0};
        vecs[1] = '{"level_high",  1'b0, 1'b1, 32'h0000_FFFF, 0, 0};
        vecs[2] = '{"dip_once",    1'b0, 1'b1, 32'h0000_FFDF, 1, 0};
        vecs[3] = '{"all_low",     1'b0, 1'b0, 32'h0000_0000, 0, 0};
        vecs[4] = '{"alternate",   1'b0, 1'b0, 32'h0000_5555, 8, 0};
        vecs[5] = '{"first_cycle", 1'b0, 1'b0, 32'h0000_0001, 1, 0};
        vecs[6] = '{"saturate",    1'b1, 1'b0, 32'h0005_5555, 7, 1};
        vecs[7] = '{"after_sat",   1'b1, 1'b0, 32'h0000_0011, 2, 0};

        // Reset held 3 cycles with start high and signal toggling.
        reset_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            ifa.signal_in = j[0];
            ifb.signal_in = j[0];
            tick();
            chk("reset.busy", int'(ifa.busy), 0);
            chk("reset.done", int'(ifa.done), 0);
            chk("reset.count", int'(ifa.count), 0);
            chk("reset.overflow", int'(ifa.overflow), 0);
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick();
        chk("reset.idle_after", int'(ifa.busy), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Starts during busy and during DONE are ignored.
        nbusy = 0; ndone = 0; done_at = -1;
        for (int j = 0; j < 40; j++) begin
            drive(1'b0, (j == 0) || (j == 5) || (j == 17), 1'b0);
            tick();
            if (ifa.busy) nbusy++;
            if (ifa.done) begin ndone++; done_at = j; end
        end
        chk("ignore.busy_cycles", nbusy, 16);
        chk("ignore.done_strobes", ndone, 1);
        chk("ignore.done_at", done_at, 16);

        // Start in the IDLE cycle right after done opens the next window.
        nbusy = 0; ndone = 0; done_at = -1;
        for (int j = 0; j < 40; j++) begin
            drive(1'b0, (j == 0) || (j == 18), 1'b0);
            tick();
            if (ifa.busy) nbusy++;
            if (ifa.done) begin ndone++; done_at = j; end
            if (j == 18) chk("b2b.busy_reopen", int'(ifa.busy), 1);
        end
        chk("b2b.busy_cycles", nbusy, 32);
        chk("b2b.done_strobes", ndone, 2);
        chk("b2b.last_done_at", done_at, 34);

        // Reset mid-window after 3 edges.
        for (int j = 0; j < 12; j++) begin
            drive(1'b0, j == 0, (j == 1) || (j == 3) || (j == 5));
            reset_n = (j == 8) ? 1'b0 : 1'b1;
            tick();
            if (j == 7) begin
                chk("midrst.count_before", int'(ifa.count), 3);
                chk("midrst.busy_before", int'(ifa.busy), 1);
            end
            if (j == 8) begin
                chk("midrst.busy", int'(ifa.busy), 0);
                chk("midrst.done", int'(ifa.done), 0);
                chk("midrst.count", int'(ifa.count), 0);
            end
        end
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (ifa.busy || ifa.done) bad++;
        end
        chk("midrst.stays_idle", bad, 0);

        // Edge-to-count latency: signal_in first sampled high at edge e5.
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        for (int j = 0; j < 20; j++) begin
            drive(1'b0, j == 0, j >= 4);
            tick();
            if (j == 3 + LAT) chk("latency.count_before", int'(ifa.count), 0);
            if (j == 4 + LAT) chk("latency.count_after", int'(ifa.count), 1);
        end
        chk("latency.final_count", int'(ifa.count), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
